// File: rtl/fractal_iter_engine.sv
// Fixed-point escape-time iterator: z <= z^2 + c in signed Q(M).(W-M), returning
// the iteration count for one pixel in Mandelbrot or Julia mode.
module fractal_iter_engine #(
    parameter int W      = 32,
    parameter int M      = 4,
    parameter int IW     = 16,
    parameter int ESC_R2 = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          mode,
    input  logic [W-1:0]  px,
    input  logic [W-1:0]  py,
    input  logic [W-1:0]  jx,
    input  logic [W-1:0]  jy,
    input  logic [IW-1:0] max_it,
    output logic          busy,
    output logic          result_valid,
    input  logic          result_ack,
    output logic [IW-1:0] iter,
    output logic          escaped
);

    localparam int F = W - M;
    localparam logic [2*W:0] ESC_LIM = (2*W+1)'(ESC_R2) << (2*F);

    typedef enum logic [2:0] {IDLE, LOAD, MUL, CHECK, DONE} state_t;

    state_t state, next_state;

    logic signed [W-1:0]   zx, zy, cx, cy;
    logic signed [2*W-1:0] xx, yy, xy;
    logic [IW-1:0]         it, max_it_q;
    logic [2*W:0]          mag2;
    logic                  is_esc, at_limit;
    logic [W-1:0]          x_next, y_next;
    logic                  unused_xy_bits;

    // Escape test uses the full-width products so it can neither overflow nor
    // miss a large |z|; the update keeps only the W bits the Q format needs.
    assign mag2     = {1'b0, xx} + {1'b0, yy};
    assign is_esc   = (mag2 >= ESC_LIM);
    assign at_limit = (it == max_it_q);
    assign x_next   = xx[F+W-1:F] - yy[F+W-1:F] + cx;
    assign y_next   = xy[F+W-2:F-1] + cy;
    assign unused_xy_bits = ^{xy[2*W-1:F+W-1], xy[F-2:0]};

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start) next_state = LOAD;
            LOAD:    next_state = MUL;
            MUL:     next_state = CHECK;
            CHECK:   if (is_esc || at_limit) next_state = DONE;
                     else                    next_state = MUL;
            DONE:    if (result_valid && result_ack) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            zx           <= '0;
            zy           <= '0;
            cx           <= '0;
            cy           <= '0;
            xx           <= '0;
            yy           <= '0;
            xy           <= '0;
            it           <= '0;
            max_it_q     <= '0;
            iter         <= '0;
            escaped      <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            unique case (state)
                LOAD: begin
                    zx       <= px;
                    zy       <= py;
                    cx       <= mode ? jx : px;
                    cy       <= mode ? jy : py;
                    it       <= '0;
                    max_it_q <= max_it;
                end
                MUL: begin
                    xx <= (2*W)'(zx) * (2*W)'(zx);
                    yy <= (2*W)'(zy) * (2*W)'(zy);
                    xy <= (2*W)'(zx) * (2*W)'(zy);
                end
                CHECK: begin
                    if (is_esc) begin
                        iter    <= it;
                        escaped <= 1'b1;
                    end else if (at_limit) begin
                        iter    <= max_it_q;
                        escaped <= 1'b0;
                    end else begin
                        zx <= x_next;
                        zy <= y_next;
                        it <= it + 1'b1;
                    end
                end
                // Valid rises one cycle after entering DONE and drops on the accepted ack.
                DONE:    result_valid <= !(result_valid && result_ack);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fractal_iter_engine.sv
// Randomized self-checking bench for fractal_iter_engine against a behavioural
// escape-time model plus hand-computed anchor cases.
module tb_fractal_iter_engine;

    localparam int W      = 32;
    localparam int M      = 4;
    localparam int F      = W - M;
    localparam int IW     = 16;
    localparam int ESC_R2 = 4;

    logic          clk = 1'b0;
    logic          reset, start, mode, result_ack;
    logic [W-1:0]  px, py, jx, jy;
    logic [IW-1:0] max_it;
    logic          busy, result_valid, escaped;
    logic [IW-1:0] iter;

    int n_vec  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    fractal_iter_engine #(.W(W), .M(M), .IW(IW), .ESC_R2(ESC_R2)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .px(px), .py(py), .jx(jx), .jy(jy), .max_it(max_it),
        .busy(busy), .result_valid(result_valid), .result_ack(result_ack),
        .iter(iter), .escaped(escaped)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Escape-time reference using 64-bit products; returns count, escape flag and update count.
    function automatic void model_pixel(input int zx0, input int zy0, input int cx, input int cy,
                                        input int mx, output int it_o, output bit esc_o,
                                        output int n_o);
        int     x = zx0;
        int     y = zy0;
        longint xx, yy, xy;
        longint lim = longint'(ESC_R2) << (2*F);
        it_o = 0; esc_o = 1'b0; n_o = 0;
        for (int it = 0; it <= mx; it++) begin
            xx = longint'(x) * longint'(x);
            yy = longint'(y) * longint'(y);
            xy = longint'(x) * longint'(y);
            if (xx >= lim - yy) begin
                it_o = it; esc_o = 1'b1; n_o = it;
                return;
            end
            if (it == mx) begin
                it_o = mx; esc_o = 1'b0; n_o = mx;
                return;
            end
            x = int'((xx >>> F) - (yy >>> F) + longint'(cx));
            y = int'((xy >>> (F-1)) + longint'(cy));
        end
    endfunction

    // Handshake/timing model: result_valid rises 4+2n edges after the accepted start.
    bit m_busy = 1'b0, m_valid = 1'b0, m_esc = 1'b0, p_esc;
    int m_iter = 0, m_wait = 0, p_iter, p_n;

    always @(posedge clk) begin
        if (reset) begin
            m_busy = 1'b0; m_valid = 1'b0; m_iter = 0; m_esc = 1'b0;
        end else if (!m_busy) begin
            if (start) begin
                model_pixel(int'(px), int'(py), mode ? int'(jx) : int'(px),
                            mode ? int'(jy) : int'(py), int'(max_it), p_iter, p_esc, p_n);
                m_wait = 4 + 2*p_n;
                m_busy = 1'b1;
            end
        end else if (m_valid) begin
            if (result_ack) begin
                m_busy = 1'b0; m_valid = 1'b0;
            end
        end else begin
            m_wait--;
            if (m_wait == 0) begin
                m_valid = 1'b1; m_iter = p_iter; m_esc = p_esc;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 64'(busy), 64'(m_busy));
            check("result_valid", 64'(result_valid), 64'(m_valid));
            if (m_valid || !m_busy) begin
                check("iter", 64'(iter), 64'(m_iter));
                check("escaped", 64'(escaped), 64'(m_esc));
            end
        end
    end

    function automatic logic [W-1:0] rand_coord(input int unsigned span);
        return W'($urandom_range(0, span)) - W'(span / 2);
    endfunction

    // Called at a negedge; returns at the negedge right after the ack edge.
    task automatic run_job(input bit md, input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic [W-1:0] cxj, input logic [W-1:0] cyj, input int mx,
                           input int ack_dly, input int exp_lat, input bit start_with_ack);
        int lat;
        mode = md; px = x; py = y; jx = cxj; jy = cyj; max_it = IW'(mx); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        px = $urandom; py = $urandom; jx = $urandom; jy = $urandom;
        mode = 1'($urandom); max_it = IW'($urandom);
        lat = 1;
        while (!result_valid && lat < 4 + 2*mx + 10) begin
            start = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check("valid_seen", 64'(result_valid), 64'd1);
        if (exp_lat >= 0) check("latency", 64'(lat), 64'(exp_lat));
        repeat (ack_dly) begin
            start = ($urandom_range(0, 3) == 0);
            @(negedge clk);
        end
        start = start_with_ack;
        result_ack = 1'b1;
        @(negedge clk);
        result_ack = 1'b0;
        start = 1'b0;
        if (start_with_ack) check("start_with_ack_ignored", 64'(busy), 64'd0);
    endtask

    int          r_it, r_n;
    bit          r_esc;
    logic [W-1:0] neg_7p5;

    initial begin
        reset = 1'b1; start = 1'b0; mode = 1'b0; result_ack = 1'b0;
        px = '0; py = '0; jx = '0; jy = '0; max_it = '0;
        neg_7p5 = 32'h8800_0000;

        // Anchor the model itself on hand-computed cases.
        model_pixel(0, 0, 0, 0, 100, r_it, r_esc, r_n);
        check("model_origin_iter", 64'(r_it), 64'd100);
        check("model_origin_esc", 64'(r_esc), 64'd0);
        model_pixel(32'h2000_0000, 0, 32'h2000_0000, 0, 100, r_it, r_esc, r_n);
        check("model_two_iter", 64'(r_it), 64'd0);
        check("model_two_esc", 64'(r_esc), 64'd1);
        model_pixel(int'(neg_7p5), 0, int'(neg_7p5), 0, 100, r_it, r_esc, r_n);
        check("model_m7p5_esc", 64'(r_esc), 64'd1);
        model_pixel(32'h1000_0000, 0, 32'h1000_0000, 0, 50, r_it, r_esc, r_n);
        check("model_one_iter", 64'(r_it), 64'd1);
        check("model_one_esc", 64'(r_esc), 64'd1);
        model_pixel(32'h1800_0000, 0, 0, 0, 100, r_it, r_esc, r_n);
        check("model_j1p5_iter", 64'(r_it), 64'd1);
        model_pixel(32'h0800_0000, 0, 0, 0, 10, r_it, r_esc, r_n);
        check("model_j0p5_iter", 64'(r_it), 64'd10);
        check("model_j0p5_esc", 64'(r_esc), 64'd0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_iter", 64'(iter), 64'd0);
        @(negedge clk);

        // Directed cases with literal latencies.
        run_job(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 100, 2, 204, 1'b0);
        run_job(1'b0, 32'h2000_0000, 32'h0, 32'h0, 32'h0, 100, 1, 4, 1'b0);
        run_job(1'b0, neg_7p5, 32'h0, 32'h0, 32'h0, 100, 0, 4, 1'b0);
        run_job(1'b0, 32'h1000_0000, 32'h0, 32'h0, 32'h0, 50, 20, 6, 1'b0);
        run_job(1'b1, 32'h1800_0000, 32'h0, 32'h0, 32'h0, 100, 3, 6, 1'b0);
        run_job(1'b1, 32'h0800_0000, 32'h0, 32'h0, 32'h0, 10, 1, 24, 1'b1);
        run_job(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 1, 4, 1'b0);
        run_job(1'b0, 32'h2000_0000, 32'h0, 32'h0, 32'h0, 0, 1, 4, 1'b0);

        // Reset while in MUL of iteration 5 aborts the pixel.
        mode = 1'b0; px = '0; py = '0; max_it = IW'(100); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_valid", 64'(result_valid), 64'd0);
        check("abort_iter", 64'(iter), 64'd0);
        run_job(1'b0, 32'h1000_0000, 32'h0, 32'h0, 32'h0, 50, 1, 6, 1'b0);

        // Randomized pixels in both modes.
        for (int j = 0; j < 40; j++) begin
            run_job(1'($urandom), rand_coord(32'h5000_0000), rand_coord(32'h5000_0000),
                    rand_coord(32'h2000_0000), rand_coord(32'h2000_0000),
                    int'($urandom_range(0, 40)), int'($urandom_range(0, 4)), -1,
                    1'($urandom_range(0, 3) == 0));
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
